// File: rtl/interrupt_acknowledge_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_acknowledge_responder_if
// Brief    : CPU-side INTA, status-read and ISR-control bundle for the responder
// Revision : 1.0 - initial release
// ============================================================================
interface interrupt_acknowledge_responder_if;
    logic       interrupt_acknowledge_n;
    logic       read_enable;
    logic       address_a0;
    logic       read_register_isr_or_irr;
    logic       auto_eoi_config;
    logic [4:0] interrupt_vector_address;
    logic [7:0] highest_priority_request;
    logic [7:0] interrupt_request_register;
    logic [7:0] in_service_register;
    logic [7:0] interrupt_mask;
    logic [7:0] data_bus_out;
    logic       data_bus_out_enable;
    logic [7:0] latch_in_service;
    logic [7:0] end_of_acknowledge_auto_eoi;
    logic       freeze_request;

    modport master (
        output interrupt_acknowledge_n, read_enable, address_a0,
               read_register_isr_or_irr, auto_eoi_config, interrupt_vector_address,
               highest_priority_request, interrupt_request_register,
               in_service_register, interrupt_mask,
        input  data_bus_out, data_bus_out_enable, latch_in_service,
               end_of_acknowledge_auto_eoi, freeze_request
    );

    modport slave (
        input  interrupt_acknowledge_n, read_enable, address_a0,
               read_register_isr_or_irr, auto_eoi_config, interrupt_vector_address,
               highest_priority_request, interrupt_request_register,
               in_service_register, interrupt_mask,
        output data_bus_out, data_bus_out_enable, latch_in_service,
               end_of_acknowledge_auto_eoi, freeze_request
    );
endinterface
`default_nettype wire

// File: rtl/interrupt_acknowledge_responder.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_acknowledge_responder
// Brief    : Answers the two-pulse 8086 INTA sequence and IRR/ISR/IMR reads
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_acknowledge_responder #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  wire logic                         clk,
    input  wire logic                         write_initial_command_word_1_reset,
    interrupt_acknowledge_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        ACK_IDLE   = 2'd0,
        ACK_FIRST  = 2'd1,
        ACK_GAP    = 2'd2,
        ACK_SECOND = 2'd3
    } ack_state_t;

    ack_state_t r_state;
    logic       r_inta_prev;
    logic [7:0] r_acknowledged_level;
    logic [7:0] r_latch_in_service;
    logic [7:0] r_end_of_acknowledge_auto_eoi;
    logic       r_freeze_request;

    logic       w_inta_assert;
    logic       w_inta_release;
    logic [7:0] w_data_bus_out;
    logic       w_data_bus_out_enable;

    assign w_inta_assert  =  r_inta_prev & ~bus.interrupt_acknowledge_n;
    assign w_inta_release = ~r_inta_prev &  bus.interrupt_acknowledge_n;

    // Highest set bit wins; an empty level means the acknowledge was spurious.
    function automatic logic [2:0] encode_level(input logic [7:0] level);
        logic [2:0] idx;
        idx = SPURIOUS_LEVEL;
        for (int i = 0; i < 8; i++) begin
            if (level[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_ff @(negedge clk or posedge write_initial_command_word_1_reset) begin
        if (write_initial_command_word_1_reset) begin
            r_state                       <= ACK_IDLE;
            r_inta_prev                   <= 1'b1;
            r_acknowledged_level          <= 8'h00;
            r_latch_in_service            <= 8'h00;
            r_end_of_acknowledge_auto_eoi <= 8'h00;
            r_freeze_request              <= 1'b0;
        end else begin
            r_inta_prev                   <= bus.interrupt_acknowledge_n;
            r_latch_in_service            <= 8'h00;
            r_end_of_acknowledge_auto_eoi <= 8'h00;
            case (r_state)
                ACK_IDLE: begin
                    if (w_inta_assert) begin
                        r_state              <= ACK_FIRST;
                        r_acknowledged_level <= bus.highest_priority_request;
                        r_latch_in_service   <= bus.highest_priority_request;
                        r_freeze_request     <= 1'b1;
                    end
                end
                ACK_FIRST: begin
                    if (w_inta_release) r_state <= ACK_GAP;
                end
                ACK_GAP: begin
                    if (w_inta_assert) r_state <= ACK_SECOND;
                end
                ACK_SECOND: begin
                    if (w_inta_release) begin
                        r_state          <= ACK_IDLE;
                        r_freeze_request <= 1'b0;
                        if (bus.auto_eoi_config && (r_acknowledged_level != 8'h00))
                            r_end_of_acknowledge_auto_eoi <= r_acknowledged_level;
                    end
                end
                default: begin
                    r_state          <= ACK_IDLE;
                    r_freeze_request <= 1'b0;
                end
            endcase
        end
    end

    // The vector phase owns the bus; status reads only while idle with INTA high.
    always_comb begin
        w_data_bus_out        = 8'h00;
        w_data_bus_out_enable = 1'b0;
        if ((r_state == ACK_SECOND) && !bus.interrupt_acknowledge_n) begin
            w_data_bus_out_enable = 1'b1;
            w_data_bus_out        = {bus.interrupt_vector_address,
                                     encode_level(r_acknowledged_level)};
        end else if ((r_state == ACK_IDLE) && bus.interrupt_acknowledge_n && bus.read_enable) begin
            w_data_bus_out_enable = 1'b1;
            if (bus.address_a0)
                w_data_bus_out = bus.interrupt_mask;
            else if (bus.read_register_isr_or_irr)
                w_data_bus_out = bus.in_service_register;
            else
                w_data_bus_out = bus.interrupt_request_register;
        end
    end

    assign bus.data_bus_out                = w_data_bus_out;
    assign bus.data_bus_out_enable         = w_data_bus_out_enable;
    assign bus.latch_in_service            = r_latch_in_service;
    assign bus.end_of_acknowledge_auto_eoi = r_end_of_acknowledge_auto_eoi;
    assign bus.freeze_request              = r_freeze_request;

endmodule
`default_nettype wire
